// File: rtl/execution_unit_mc.sv
// execution_unit_mc: single-cycle ALU with an iterative shift-add multiplier
// and an optional restoring divider, behind an IDLE/BUSY issue handshake.
// Ports: clock, reset (sync, active-high); ALU_operation, PC,
//   operand_A_sel, operand_B_sel, branch_op, rs1_data, rs2_data, extend,
//   issue_valid, flush, scan in; issue_ready, result_valid, ALU_result,
//   branch, JALR_target out.
// Define EXECUTION_UNIT_DIV_EN to build the divider (opcodes 36-39);
// otherwise those opcodes complete in one cycle with a zero result.
module execution_unit_mc #(
  parameter int CORE         = 0,
  parameter int DATA_WIDTH   = 32,
  parameter int ADDRESS_BITS = 20
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [5:0]              ALU_operation,
  input  logic [ADDRESS_BITS-1:0] PC,
  input  logic [1:0]              operand_A_sel,
  input  logic                    operand_B_sel,
  input  logic                    branch_op,
  input  logic [DATA_WIDTH-1:0]   rs1_data,
  input  logic [DATA_WIDTH-1:0]   rs2_data,
  input  logic [DATA_WIDTH-1:0]   extend,
  input  logic                    issue_valid,
  input  logic                    flush,
  input  logic                    scan,
  output logic                    issue_ready,
  output logic                    result_valid,
  output logic [DATA_WIDTH-1:0]   ALU_result,
  output logic                    branch,
  output logic [ADDRESS_BITS-1:0] JALR_target
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W + 1);
  localparam int SW = $clog2(W);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                  state;
  logic [CW-1:0]           cnt;
  logic [ADDRESS_BITS-1:0] jalr_q;

  logic [W-1:0]            op_a;
  logic [W-1:0]            op_b;
  logic [W-1:0]            alu_out;
  logic [SW-1:0]           shamt;
  logic [W-1:0]            jalr_sum;
  logic [ADDRESS_BITS-1:0] jalr_now;
  logic                    is_mul;
  logic                    multi;

  logic                    a_sgn;
  logic                    b_sgn;
  logic                    a_neg;
  logic                    b_neg;
  logic [W-1:0]            a_mag;
  logic [W-1:0]            b_mag;

  logic [2*W-1:0]          m_prod;
  logic [2*W-1:0]          m_cand;
  logic [W-1:0]            m_plier;
  logic                    m_neg;
  logic                    m_high;
  logic [2*W-1:0]          m_fix;
  logic [W-1:0]            m_res;

  logic                    unused_bits;

  assign issue_ready = (state == IDLE);

  always_comb begin
    op_a = rs1_data;
    unique case (operand_A_sel)
      2'd1:    op_a = W'(PC);
      2'd2:    op_a = '0;
      default: op_a = rs1_data;
    endcase
  end

  assign op_b  = operand_B_sel ? extend : rs2_data;
  assign shamt = op_b[SW-1:0];

  always_comb begin
    alu_out = '0;
    unique case (ALU_operation)
      6'd0:  alu_out = op_a + op_b;
      6'd2:  alu_out = {{(W-1){1'b0}},
                        $signed(op_a) < $signed(op_b)};
      6'd3:  alu_out = {{(W-1){1'b0}}, op_a < op_b};
      6'd4:  alu_out = op_a ^ op_b;
      6'd6:  alu_out = op_a | op_b;
      6'd10: alu_out = op_a & op_b;
      6'd11: alu_out = op_a << shamt;
      6'd12: alu_out = op_a >> shamt;
      6'd13: alu_out = $signed(op_a) >>> shamt;
      6'd14: alu_out = op_a - op_b;
      6'd16: alu_out = {{(W-1){1'b0}}, op_a == op_b};
      6'd17: alu_out = {{(W-1){1'b0}}, op_a != op_b};
      6'd20: alu_out = {{(W-1){1'b0}},
                        $signed(op_a) < $signed(op_b)};
      6'd21: alu_out = {{(W-1){1'b0}},
                        $signed(op_a) >= $signed(op_b)};
      6'd22: alu_out = {{(W-1){1'b0}}, op_a < op_b};
      6'd23: alu_out = {{(W-1){1'b0}}, op_a >= op_b};
      6'd31: alu_out = op_b;
      default: alu_out = '0;
    endcase
  end

  assign jalr_sum = rs1_data + extend;
  assign jalr_now = {jalr_sum[ADDRESS_BITS-1:1], 1'b0};

  assign is_mul = (ALU_operation[5:2] == 4'b1000);

  // Signedness: MUL/MULH both signed, MULHSU A only, MULHU none;
  // DIV/REM signed, DIVU/REMU unsigned (bit 0 selects unsigned).
  always_comb begin
    a_sgn = 1'b0;
    b_sgn = 1'b0;
    if (is_mul) begin
      a_sgn = (ALU_operation[1:0] != 2'b11);
      b_sgn = !ALU_operation[1];
    end else begin
      a_sgn = !ALU_operation[0];
      b_sgn = !ALU_operation[0];
    end
  end

  assign a_neg = a_sgn & op_a[W-1];
  assign b_neg = b_sgn & op_b[W-1];
  assign a_mag = a_neg ? -op_a : op_a;
  assign b_mag = b_neg ? -op_b : op_b;

  assign m_fix = m_neg ? -m_prod : m_prod;
  assign m_res = m_high ? m_fix[2*W-1:W] : m_fix[W-1:0];

`ifdef EXECUTION_UNIT_DIV_EN
  logic         is_div;
  logic         div_q;
  logic [W-1:0] d_rem;
  logic [W-1:0] d_quot;
  logic [W-1:0] d_dvs;
  logic         d_qneg;
  logic         d_rneg;
  logic         d_want_rem;
  logic [W:0]   d_shift;
  logic [W:0]   d_diff;
  logic         d_take;
  logic [W-1:0] d_qfix;
  logic [W-1:0] d_rfix;
  logic [W-1:0] d_res;

  assign is_div  = (ALU_operation[5:2] == 4'b1001);
  assign multi   = is_mul | is_div;

  // Remainder never exceeds the divisor, so W bits hold it once
  // the trial subtraction has been applied.
  assign d_shift = {d_rem, d_quot[W-1]};
  assign d_take  = (d_shift >= {1'b0, d_dvs});
  assign d_diff  = d_shift - {1'b0, d_dvs};

  assign d_qfix  = d_qneg ? -d_quot : d_quot;
  assign d_rfix  = d_rneg ? -d_rem : d_rem;
  assign d_res   = d_want_rem ? d_rfix : d_qfix;

  assign unused_bits = ^{scan, jalr_sum, CORE != 0,
                         d_diff[W], d_shift[W]};
`else
  assign multi       = is_mul;
  assign unused_bits = ^{scan, jalr_sum, CORE != 0};
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      result_valid <= 1'b0;
      ALU_result   <= '0;
      branch       <= 1'b0;
      JALR_target  <= '0;
      jalr_q       <= '0;
      m_prod       <= '0;
      m_cand       <= '0;
      m_plier      <= '0;
      m_neg        <= 1'b0;
      m_high       <= 1'b0;
`ifdef EXECUTION_UNIT_DIV_EN
      div_q        <= 1'b0;
      d_rem        <= '0;
      d_quot       <= '0;
      d_dvs        <= '0;
      d_qneg       <= 1'b0;
      d_rneg       <= 1'b0;
      d_want_rem   <= 1'b0;
`endif
    end else begin
      result_valid <= 1'b0;
      if (flush) begin
        state <= IDLE;
        cnt   <= '0;
      end else if (state == IDLE) begin
        if (issue_valid) begin
          if (multi) begin
            state   <= BUSY;
            cnt     <= '0;
            jalr_q  <= jalr_now;
            m_prod  <= '0;
            m_cand  <= {{W{1'b0}}, a_mag};
            m_plier <= b_mag;
            m_neg   <= a_neg ^ b_neg;
            m_high  <= (ALU_operation[1:0] != 2'b00);
`ifdef EXECUTION_UNIT_DIV_EN
            div_q      <= is_div;
            d_rem      <= '0;
            d_quot     <= a_mag;
            d_dvs      <= b_mag;
            // x/0 keeps an all-ones quotient regardless of sign.
            d_qneg     <= (a_neg ^ b_neg) && (op_b != '0);
            d_rneg     <= a_neg;
            d_want_rem <= ALU_operation[1];
`endif
          end else begin
            result_valid <= 1'b1;
            ALU_result   <= alu_out;
            branch       <= branch_op && (alu_out != '0);
            JALR_target  <= jalr_now;
          end
        end
      end else if (cnt != CW'(W)) begin
        cnt <= cnt + 1'b1;
        if (m_plier[0]) m_prod <= m_prod + m_cand;
        m_cand  <= m_cand << 1;
        m_plier <= m_plier >> 1;
`ifdef EXECUTION_UNIT_DIV_EN
        d_rem  <= d_take ? d_diff[W-1:0] : d_shift[W-1:0];
        d_quot <= {d_quot[W-2:0], d_take};
`endif
      end else begin
        state        <= IDLE;
        cnt          <= '0;
        result_valid <= 1'b1;
        branch       <= 1'b0;
        JALR_target  <= jalr_q;
        ALU_result   <= m_res;
`ifdef EXECUTION_UNIT_DIV_EN
        if (div_q) ALU_result <= d_res;
`endif
      end
    end
  end

endmodule

// File: tb/tb_execution_unit_mc.sv
// tb_execution_unit_mc: directed bench with an arithmetic reference model
// compared against the DUT on every cycle, plus literal spot checks.
module tb_execution_unit_mc;

  localparam int W  = 32;
  localparam int AB = 20;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [5:0]    ALU_operation = '0;
  logic [AB-1:0] PC = '0;
  logic [1:0]    operand_A_sel = '0;
  logic          operand_B_sel = 1'b0;
  logic          branch_op = 1'b0;
  logic [W-1:0]  rs1_data = '0;
  logic [W-1:0]  rs2_data = '0;
  logic [W-1:0]  extend = '0;
  logic          issue_valid = 1'b0;
  logic          flush = 1'b0;
  logic          scan = 1'b0;
  logic          issue_ready;
  logic          result_valid;
  logic [W-1:0]  ALU_result;
  logic          branch;
  logic [AB-1:0] JALR_target;

  execution_unit_mc #(
    .CORE(0),
    .DATA_WIDTH(W),
    .ADDRESS_BITS(AB)
  ) dut (
    .clock(clk),
    .reset(reset),
    .ALU_operation(ALU_operation),
    .PC(PC),
    .operand_A_sel(operand_A_sel),
    .operand_B_sel(operand_B_sel),
    .branch_op(branch_op),
    .rs1_data(rs1_data),
    .rs2_data(rs2_data),
    .extend(extend),
    .issue_valid(issue_valid),
    .flush(flush),
    .scan(scan),
    .issue_ready(issue_ready),
    .result_valid(result_valid),
    .ALU_result(ALU_result),
    .branch(branch),
    .JALR_target(JALR_target)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int rv_count = 0;
  bit chk_en = 1'b0;

  task automatic cmp(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got %h expected %h",
               name, $time, act, exp);
    end
  endtask

  // Reference model: results from plain arithmetic on the opcode rules.
  function automatic logic [31:0] model_op(input logic [5:0] op,
                                           input logic [31:0] a,
                                           input logic [31:0] b,
                                           output bit mc);
    logic [63:0] xa, xb, p;
    logic [31:0] q, rm;
    bit sg;
    mc = 1'b0;
    model_op = '0;
    if (op < 32) begin
      case (op)
        6'd0:  model_op = a + b;
        6'd10: model_op = a & b;
        6'd12: model_op = a >> b[4:0];
        6'd14: model_op = a - b;
        6'd16: model_op = (a == b) ? 32'd1 : 32'd0;
        default: model_op = '0;
      endcase
    end else if (op < 36) begin
      mc = 1'b1;
      xa = (op != 35) ? {{32{a[31]}}, a} : {32'b0, a};
      xb = (op <= 33) ? {{32{b[31]}}, b} : {32'b0, b};
      p  = xa * xb;
      model_op = (op == 32) ? p[31:0] : p[63:32];
    end else if (op < 40) begin
`ifdef EXECUTION_UNIT_DIV_EN
      mc = 1'b1;
      sg = (op == 36) || (op == 38);
      if (b == 0) begin
        q  = 32'hFFFF_FFFF;
        rm = a;
      end else if (sg && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        q  = a;
        rm = 32'h0;
      end else if (sg) begin
        q  = $signed(a) / $signed(b);
        rm = $signed(a) % $signed(b);
      end else begin
        q  = a / b;
        rm = a % b;
      end
      model_op = (op <= 37) ? q : rm;
`else
      sg = 1'b0;
      q  = '0;
      rm = '0;
      model_op = (sg ? q : rm);
`endif
    end
  endfunction

  bit            m_busy = 1'b0;
  int            m_left = 0;
  logic [31:0]   m_pres;
  logic [AB-1:0] m_pjt;
  logic          m_rv = 1'b0;
  logic [31:0]   m_res;
  logic          m_br;
  logic [AB-1:0] m_jt;

  always @(posedge clk) begin : model
    logic [31:0] a, b, r, s;
    logic [AB-1:0] jt;
    bit mc;
    m_rv = 1'b0;
    if (reset) begin
      m_busy = 1'b0;
      m_res  = '0;
      m_br   = 1'b0;
      m_jt   = '0;
    end else if (flush) begin
      m_busy = 1'b0;
    end else if (m_busy) begin
      m_left--;
      if (m_left == 0) begin
        m_busy = 1'b0;
        m_rv   = 1'b1;
        m_res  = m_pres;
        m_br   = 1'b0;
        m_jt   = m_pjt;
      end
    end else if (issue_valid) begin
      a = (operand_A_sel == 2'd1) ? {12'b0, PC} :
          (operand_A_sel == 2'd2) ? 32'h0 : rs1_data;
      b = operand_B_sel ? extend : rs2_data;
      s = rs1_data + extend;
      jt = s[AB-1:0] & 20'hFFFFE;
      r = model_op(ALU_operation, a, b, mc);
      if (mc) begin
        m_busy = 1'b1;
        m_left = W + 1;
        m_pres = r;
        m_pjt  = jt;
      end else begin
        m_rv  = 1'b1;
        m_res = r;
        m_br  = branch_op && (r != 0);
        m_jt  = jt;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      cmp("result_valid", result_valid, m_rv);
      cmp("issue_ready", issue_ready, !m_busy);
      cmp("ALU_result", ALU_result, m_res);
      cmp("branch", branch, m_br);
      cmp("JALR_target", JALR_target, m_jt);
    end
    if (result_valid) rv_count++;
  end

  task automatic setop(input logic [5:0] op, input logic [1:0] asel,
                       input logic bsel, input logic bop,
                       input logic [31:0] r1, input logic [31:0] r2,
                       input logic [31:0] ext);
    ALU_operation = op;
    operand_A_sel = asel;
    operand_B_sel = bsel;
    branch_op     = bop;
    rs1_data      = r1;
    rs2_data      = r2;
    extend        = ext;
  endtask

  // Issue one op, return at the negedge after its accept edge.
  task automatic single(input logic [5:0] op, input logic [1:0] asel,
                        input logic bsel, input logic bop,
                        input logic [31:0] r1, input logic [31:0] r2,
                        input logic [31:0] ext);
    setop(op, asel, bsel, bop, r1, r2, ext);
    issue_valid = 1'b1;
    @(posedge clk);
    #1 issue_valid = 1'b0;
    @(negedge clk);
  endtask

  // Returns at the negedge where result_valid is seen; lat counts
  // edges after the accept edge.
  task automatic wait_rv(input int budget, output int lat);
    lat = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (result_valid) begin
        lat = i;
        return;
      end
    end
    checks++;
    errors++;
    $display("FAIL wait_rv timeout after %0d cycles", budget);
  endtask

  task automatic multi(input logic [5:0] op,
                       input logic [31:0] r1, input logic [31:0] r2,
                       output int lat);
    setop(op, 2'd0, 1'b0, 1'b1, r1, r2, 32'h0);
    issue_valid = 1'b1;
    @(posedge clk);
    #1 issue_valid = 1'b0;
    wait_rv(80, lat);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int rvc;
    @(posedge clk);
    #1 chk_en = 1'b1;
    @(negedge clk);
    cmp("rst_result", ALU_result, 32'h0);
    cmp("rst_valid", result_valid, 1'b0);
    cmp("rst_ready", issue_ready, 1'b1);
    cmp("rst_jalr", JALR_target, 20'h0);
    reset = 1'b0;

    // SRL then SUB back to back.
    setop(6'd12, 2'd0, 1'b0, 1'b0, 32'd15, 32'd2, 32'd0);
    issue_valid = 1'b1;
    @(posedge clk);
    #1 setop(6'd14, 2'd0, 1'b0, 1'b0, 32'd5, 32'd7, 32'd0);
    @(negedge clk);
    cmp("srl_valid", result_valid, 1'b1);
    cmp("srl_result", ALU_result, 32'h0000_0003);
    @(posedge clk);
    #1 issue_valid = 1'b0;
    @(negedge clk);
    cmp("sub_valid", result_valid, 1'b1);
    cmp("sub_result", ALU_result, 32'hFFFF_FFFE);

    single(6'd10, 2'd0, 1'b1, 1'b0, 32'd4, 32'd0, 32'd4);
    cmp("and_imm", ALU_result, 32'h0000_0004);

    PC = 20'h00100;
    single(6'd0, 2'd1, 1'b1, 1'b0, 32'h1001, 32'd0, 32'd4);
    cmp("add_pc", ALU_result, 32'h0000_0104);
    cmp("jalr_tgt", JALR_target, 20'h01004);

    single(6'd0, 2'd2, 1'b0, 1'b0, 32'd123, 32'd77, 32'd0);
    cmp("add_zeroA", ALU_result, 32'd77);

    single(6'd16, 2'd0, 1'b0, 1'b1, 32'd5, 32'd6, 32'd0);
    cmp("beq_ne", branch, 1'b0);
    single(6'd16, 2'd0, 1'b0, 1'b1, 32'd5, 32'd5, 32'd0);
    cmp("beq_eq", branch, 1'b1);

    multi(6'd32, 32'd7, 32'hFFFF_FFFD, lat);
    cmp("mul_lat", lat, 33);
    cmp("mul_result", ALU_result, 32'hFFFF_FFEB);
    cmp("mul_branch", branch, 1'b0);
    multi(6'd33, 32'd7, 32'hFFFF_FFFD, lat);
    cmp("mulh_result", ALU_result, 32'hFFFF_FFFF);
    multi(6'd35, 32'hFFFF_FFFF, 32'd2, lat);
    cmp("mulhu_result", ALU_result, 32'h0000_0001);
    multi(6'd34, 32'hFFFF_FFFF, 32'd2, lat);
    cmp("mulhsu_result", ALU_result, 32'hFFFF_FFFF);

`ifdef EXECUTION_UNIT_DIV_EN
    multi(6'd36, 32'd100, 32'hFFFF_FFF9, lat);
    cmp("div_lat", lat, 33);
    cmp("div_result", ALU_result, 32'hFFFF_FFF2);
    multi(6'd38, 32'd100, 32'hFFFF_FFF9, lat);
    cmp("rem_result", ALU_result, 32'h0000_0002);
    multi(6'd37, 32'd5, 32'd0, lat);
    cmp("divu_zero_lat", lat, 33);
    cmp("divu_zero", ALU_result, 32'hFFFF_FFFF);
    multi(6'd39, 32'd5, 32'd0, lat);
    cmp("remu_zero", ALU_result, 32'h0000_0005);
    multi(6'd36, 32'h8000_0000, 32'hFFFF_FFFF, lat);
    cmp("div_ovf", ALU_result, 32'h8000_0000);
`else
    single(6'd36, 2'd0, 1'b0, 1'b1, 32'd100, 32'hFFFF_FFF9, 32'd0);
    cmp("div_off_valid", result_valid, 1'b1);
    cmp("div_off_result", ALU_result, 32'h0);
    cmp("div_off_branch", branch, 1'b0);
`endif

    // Flush mid-multiply.
    single(6'd14, 2'd0, 1'b0, 1'b0, 32'd10, 32'd3, 32'd0);
    cmp("pre_flush", ALU_result, 32'd7);
    setop(6'd32, 2'd0, 1'b0, 1'b0, 32'd9, 32'd9, 32'd0);
    issue_valid = 1'b1;
    @(posedge clk);
    #1 issue_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    cmp("flush_ready", issue_ready, 1'b1);
    cmp("flush_keep", ALU_result, 32'd7);
    rvc = rv_count;
    repeat (40) @(negedge clk);
    cmp("flush_no_rv", rv_count - rvc, 0);

    // Flush beats a simultaneous issue.
    setop(6'd0, 2'd0, 1'b0, 1'b0, 32'd1, 32'd1, 32'd0);
    issue_valid = 1'b1;
    flush = 1'b1;
    @(posedge clk);
    #1 issue_valid = 1'b0;
    flush = 1'b0;
    @(negedge clk);
    cmp("flush_issue_rv", result_valid, 1'b0);
    cmp("flush_issue_keep", ALU_result, 32'd7);

    // Reset mid multi-cycle op.
`ifdef EXECUTION_UNIT_DIV_EN
    setop(6'd36, 2'd0, 1'b0, 1'b0, 32'd1000, 32'd3, 32'd0);
`else
    setop(6'd33, 2'd0, 1'b0, 1'b0, 32'd1000, 32'd3, 32'd0);
`endif
    issue_valid = 1'b1;
    @(posedge clk);
    #1 issue_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    cmp("rst_mid_ready", issue_ready, 1'b1);
    cmp("rst_mid_result", ALU_result, 32'h0);
    rvc = rv_count;
    repeat (40) @(negedge clk);
    cmp("rst_mid_no_rv", rv_count - rvc, 0);

    // Issue held while busy; accepted once ready returns.
    setop(6'd32, 2'd0, 1'b0, 1'b0, 32'd7, 32'hFFFF_FFFD, 32'd0);
    issue_valid = 1'b1;
    @(posedge clk);
    #1 setop(6'd12, 2'd0, 1'b0, 1'b0, 32'd15, 32'd2, 32'd0);
    wait_rv(80, lat);
    cmp("held_mul_lat", lat, 33);
    cmp("held_mul_result", ALU_result, 32'hFFFF_FFEB);
    cmp("held_ready", issue_ready, 1'b1);
    @(posedge clk);
    #1 issue_valid = 1'b0;
    @(negedge clk);
    cmp("held_srl_valid", result_valid, 1'b1);
    cmp("held_srl_result", ALU_result, 32'h0000_0003);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
